// File: rtl/sign_ext_pkg.sv
// Shared definitions for narrowing/extension blocks: overflow counter sizing,
// result-buffer occupancy encoding and the range-fit check.
package sign_ext_pkg;

    localparam int unsigned OVF_CNT_W   = 8;
    localparam int unsigned OVF_CNT_MAX = 255;

    // Widest source the fit check can handle; callers zero-extend into it.
    localparam int unsigned FIT_MAX_W = 64;
    localparam int unsigned FIT_IDX_W = 6;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_occ_e;

    // Does an n-bit value fit in m bits? Signed: bits [n-1:m-1] all equal.
    // Unsigned: bits [n-1:m] all zero.
    function automatic logic fits_narrow(
        input logic [FIT_MAX_W-1:0] data,
        input int unsigned          n,
        input int unsigned          m,
        input logic                 is_signed
    );
        logic ok;
        logic msb;
        ok  = 1'b1;
        msb = data[FIT_IDX_W'(n - 1)];
        for (int unsigned i = 0; i < FIT_MAX_W; i++) begin
            if (i < n) begin
                if (is_signed && (i >= m - 1) && (data[FIT_IDX_W'(i)] != msb)) begin
                    ok = 1'b0;
                end
                if (!is_signed && (i >= m) && data[FIT_IDX_W'(i)]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    // Saturating increment for overflow event counters.
    function automatic logic [OVF_CNT_W-1:0] ovf_cnt_inc(input logic [OVF_CNT_W-1:0] cnt);
        return (cnt == OVF_CNT_W'(OVF_CNT_MAX)) ? cnt : cnt + OVF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sign_trunc_fifo2.sv
// Two-entry valid/ready result buffer. Head is a register so the output holds
// while stalled; in_ready depends only on registered occupancy.
module sign_trunc_fifo2
    import sign_ext_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    fifo_occ_e    r_occ;
    fifo_occ_e    w_occ_next;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         r_out_valid;
    logic         r_in_ready;
    logic         w_push;
    logic         w_pop;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= FIFO_EMPTY;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    // Next occupancy
    always_comb begin
        w_occ_next = r_occ;
        case (r_occ)
            FIFO_EMPTY: if (w_push)            w_occ_next = FIFO_ONE;
            FIFO_ONE: begin
                if (w_push && !w_pop)          w_occ_next = FIFO_FULL;
                else if (!w_push && w_pop)     w_occ_next = FIFO_EMPTY;
            end
            FIFO_FULL:  if (w_pop)             w_occ_next = FIFO_ONE;
            default:                           w_occ_next = FIFO_EMPTY;
        endcase
    end

    // Storage and handshake flags, all derived from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= (w_occ_next != FIFO_EMPTY);
            r_in_ready  <= (w_occ_next != FIFO_FULL);
            case (r_occ)
                FIFO_EMPTY: begin
                    if (w_push) r_head <= in_data;
                end
                FIFO_ONE: begin
                    if (w_push && w_pop) r_head <= in_data;
                    else if (w_push)     r_tail <= in_data;
                end
                FIFO_FULL: begin
                    if (w_pop) r_head <= r_tail;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;

endmodule

// File: rtl/sign_truncation.sv
// Narrows an N-bit word to M bits with signed/unsigned range check, optional
// saturation, a two-entry output buffer and overflow statistics.
module sign_truncation
    import sign_ext_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic                 in_signed,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M-1:0]         out_data,
    output logic                 out_ovf,
    output logic                 ovf_sticky,
    output logic [OVF_CNT_W-1:0] ovf_count,
    input  logic                 clr_ovf
);

    logic                 w_fit;
    logic [M-1:0]         w_sat_val;
    logic [M-1:0]         w_narrow;
    logic [M:0]           w_result;
    logic                 w_fifo_in_ready;
    logic [M:0]           w_fifo_out;
    logic                 w_in_fire;
    logic                 w_ovf_event;
    logic                 r_ovf_sticky;
    logic [OVF_CNT_W-1:0] r_ovf_count;

    // Range check and saturation/wrap selection
    always_comb begin
        w_fit     = fits_narrow(FIT_MAX_W'(in_data), N, M, in_signed);
        w_sat_val = '1;
        if (in_signed) begin
            w_sat_val = in_data[N-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
        end
        w_narrow = in_data[M-1:0];
        if (!w_fit && sat_en) begin
            w_narrow = w_sat_val;
        end
        w_result = {!w_fit, w_narrow};
    end

    // Nothing is accepted while reset is asserted
    assign in_ready    = !rst && w_fifo_in_ready;
    assign w_in_fire   = in_valid && in_ready;
    assign w_ovf_event = w_in_fire && !w_fit;

    sign_trunc_fifo2 #(
        .W (M + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_fire),
        .in_ready  (w_fifo_in_ready),
        .in_data   (w_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_fifo_out)
    );

    // A clear coinciding with an overflow leaves that overflow recorded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_count  <= '0;
        end else if (clr_ovf) begin
            r_ovf_sticky <= w_ovf_event;
            r_ovf_count  <= OVF_CNT_W'(w_ovf_event);
        end else if (w_ovf_event) begin
            r_ovf_sticky <= 1'b1;
            r_ovf_count  <= ovf_cnt_inc(r_ovf_count);
        end
    end

    assign out_data   = w_fifo_out[M-1:0];
    assign out_ovf    = w_fifo_out[M];
    assign ovf_sticky = r_ovf_sticky;
    assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_sign_truncation.sv
// Bench for sign_truncation: directed literal cases plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_sign_truncation;

    localparam int unsigned M = 4;
    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_signed;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_data;
    logic         out_ovf;
    logic         ovf_sticky;
    logic [7:0]   ovf_count;
    logic         clr_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sign_truncation #(.M(M), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_signed  (in_signed),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr_ovf    (clr_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {ovf, data} from plain integer range arithmetic
    function automatic logic [M:0] model_out(input logic [N-1:0] d, input bit sg, input bit st);
        int v, lo, hi, half;
        bit fit;
        logic [M-1:0] r;
        half = 1 << (M - 1);
        if (sg) begin
            v  = int'($signed(d));
            lo = -half;
            hi = half - 1;
        end else begin
            v  = int'(d);
            lo = 0;
            hi = (1 << M) - 1;
        end
        fit = (v >= lo) && (v <= hi);
        r   = d[M-1:0];
        if (!fit && st) r = (v > hi) ? M'(hi) : M'(lo);
        return {!fit, r};
    endfunction

    // Behavioural model: FIFO as a queue, overflow statistics as integers
    logic [M:0] mq[$];
    bit         m_sticky = 0;
    int         m_count  = 0;
    bit         m_live   = 0;
    bit         m_acc, m_pop, m_ev;
    logic [M:0] m_res;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_sticky = 0;
            m_count  = 0;
            m_live   = 1;
        end else if (m_live) begin
            m_acc = in_valid && (mq.size() < 2);
            m_pop = (mq.size() > 0) && out_ready;
            m_res = model_out(in_data, in_signed, sat_en);
            m_ev  = m_acc && m_res[M];
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(m_res);
            if (clr_ovf) begin
                m_sticky = m_ev;
                m_count  = m_ev ? 1 : 0;
            end else if (m_ev) begin
                m_sticky = 1;
                m_count  = (m_count < 255) ? m_count + 1 : 255;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", 32'(in_ready), 32'(!rst && (mq.size() < 2)));
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("out_word", 32'({out_ovf, out_data}), 32'(mq[0]));
            chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
            chk("ovf_count", 32'(ovf_count), 32'(m_count));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one word with the consumer ready; check it one cycle later
    task automatic send(input logic [N-1:0] d, input bit sg, input bit st,
                        input logic [M:0] exp, input string nm);
        in_data   = d;
        in_signed = sg;
        sat_en    = st;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk(nm, 32'({out_ovf, out_data}), 32'(exp));
        cyc();
    endtask

    function automatic logic [N-1:0] rand_word();
        int s;
        s = int'($urandom_range(0, 40)) - 20;
        case ($urandom_range(0, 3))
            0:       return N'($urandom);
            1:       return N'(s);
            2:       return N'($urandom_range(0, 40));
            default: return {N'($urandom_range(0, 3)) << (N - 2)} | N'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
        sat_en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;

        chk("model_fff7", 32'(model_out(16'hFFF7, 1, 1)), 32'h18);
        chk("model_001f", 32'(model_out(16'h001F, 0, 0)), 32'h1F);

        // Reset state
        cyc(); cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", 32'({out_ovf, out_data}), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Signed saturating boundaries
        send(16'h0007, 1, 1, 5'h07, "s_0007");
        send(16'h0008, 1, 1, 5'h17, "s_0008");
        send(16'hFFF8, 1, 1, 5'h08, "s_fff8");
        send(16'hFFF7, 1, 1, 5'h18, "s_fff7");
        chk("s_count", 32'(ovf_count), 32'd2);
        chk("s_sticky", 32'(ovf_sticky), 32'd1);

        // Unsigned wrap and saturate
        send(16'h000F, 0, 0, 5'h0F, "u_000f");
        send(16'h001F, 0, 0, 5'h1F, "u_001f");
        send(16'h8000, 0, 0, 5'h10, "u_8000w");
        send(16'h8000, 0, 1, 5'h1F, "u_8000s");

        // Back-pressure: A,B buffered, C refused, then ordered drain
        out_ready = 1'b0; in_signed = 1'b1; sat_en = 1'b1; in_valid = 1'b1;
        in_data = 16'h0003; cyc();
        in_data = 16'h0005; cyc();
        in_data = 16'h0001;
        chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_head_a", 32'(out_data), 32'h3);
        cyc();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold_a", 32'(out_data), 32'h3);
        out_ready = 1'b1; cyc();
        chk("bp_head_b", 32'(out_data), 32'h5);
        cyc();
        in_valid = 1'b0;
        chk("bp_head_c", 32'(out_data), 32'h1);
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Counter saturation and clear interaction
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        in_data = 16'h7FFF; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) cyc();
        in_valid = 1'b0;
        chk("cnt_sat", 32'(ovf_count), 32'd255);
        chk("cnt_sticky", 32'(ovf_sticky), 32'd1);
        in_valid = 1'b1; clr_ovf = 1'b1; cyc();
        in_valid = 1'b0; clr_ovf = 1'b0;
        chk("clr_ovf_cnt", 32'(ovf_count), 32'd1);
        chk("clr_ovf_sticky", 32'(ovf_sticky), 32'd1);
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        chk("clr_cnt", 32'(ovf_count), 32'd0);
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);

        // Reset with two words buffered
        cyc();
        out_ready = 1'b0; in_data = 16'h0100; in_valid = 1'b1;
        cyc(); cyc();
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(ovf_count), 32'd0);
        rst = 1'b0;
        send(16'hFFFD, 1, 0, 5'h0D, "post_rst_word");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            clr_ovf   = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_signed = 1'($urandom_range(0, 1));
            sat_en    = 1'($urandom_range(0, 1));
            in_data   = rand_word();
            cyc();
        end
        rst = 1'b0; clr_ovf = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("drained", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
